// File: rtl/cla_seq_add_if.sv
// Operand/result port bundle for the multi-cycle wide adder sequencer.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface cla_seq_add_if #(
  parameter int DW = 64
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] sum;
  logic          cout;
  logic          ovf;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Sequencer side
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_seq_add.sv
// Wide adder: feeds a DW-bit operand pair through one 32-bit CLA, one slice per cycle, LSB first.
// Latency: accept edge + DW/32 edges until out_valid; one op per DW/32+2 cycles at full rate.
// Backpressure: result held stable while out_ready=0; in_ready is low from accept until result drains.

// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout,
  output logic        gen,
  output logic        prop
);
  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [8:0]  gc;
  logic        blk_g;

  // Bit/group generate-propagate, group carries, lookahead bit carries, sum
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    gg    = '0;
    gp    = '0;
    gc    = '0;
    c     = '0;
    blk_g = 1'b0;
    for (int j = 0; j < 8; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    gc[0] = cin;
    for (int j = 0; j < 8; j++) begin
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    end
    for (int j = 0; j < 8; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    for (int j = 0; j < 8; j++) begin
      blk_g = gg[j] | (gp[j] & blk_g);
    end
    s    = p ^ c;
    cout = gc[8];
    gen  = blk_g;
    prop = &gp;
  end
endmodule

module cla_seq_add #(
  parameter int DW = 64,
  parameter int SW = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  cla_seq_add_if.slave io
);
  localparam int NS = DW / SW;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NS - 1);

  // The slice adder is a fixed 32-bit CLA; anything else cannot be built.
  generate
    if (SW != 32) begin : g_bad_sw
      $error("cla_seq_add: SW must be 32");
    end
    if ((DW < SW) || ((DW % SW) != 0)) begin : g_bad_dw
      $error("cla_seq_add: DW must be a non-zero multiple of SW");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  int            slice_lo;
  logic [SW-1:0] cla_a;
  logic [SW-1:0] cla_b;
  logic [SW-1:0] cla_s;
  logic          cla_cout;
  logic          cla_gen;
  logic          cla_prop;
  logic          unused_cla;

  // Current slice of the captured operands goes to the adder with the chained carry.
  assign slice_lo = SW * int'(cnt_q);
  assign cla_a    = a_q[slice_lo +: SW];
  assign cla_b    = b_q[slice_lo +: SW];

  cla32bits u_cla (
    .a    (cla_a),
    .b    (cla_b),
    .cin  (carry_q),
    .s    (cla_s),
    .cout (cla_cout),
    .gen  (cla_gen),
    .prop (cla_prop)
  );

  // Group generate/propagate are not needed; carry chains through cout only.
  assign unused_cla = cla_gen ^ cla_prop;

  // Outputs depend on state and registers only, never directly on in_valid/out_ready.
  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;
  assign io.ovf       = ovf_q;

  // Next-state: accept in IDLE, one slice per cycle in RUN, hold result in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.a;
          b_d     = io.b;
          carry_d = io.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[slice_lo +: SW] = cla_s;
        if (cnt_q == LAST) begin
          cout_d  = cla_cout;
          // Same-sign operands whose top sum bit differs from them overflowed.
          ovf_d   = (a_q[DW-1] == b_q[DW-1]) && (cla_s[SW-1] != a_q[DW-1]);
          state_d = DONE;
        end else begin
          carry_d = cla_cout;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: tb/tb_cla_seq_add.sv
// Bench for cla_seq_add: 64-bit instance against an arithmetic model, 128-bit instance for mid-run reset.
// Latency: model expects out_valid exactly NS+1 negedges after the accept negedge.
// Backpressure: out_ready randomised, plus a directed 5-cycle stall with a pending new operand.
module tb_cla_seq_add;
  localparam int NS = 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic rst128_n = 1'b0;

  always #5 clk = ~clk;

  cla_seq_add_if #(.DW(64))  if64 ();
  cla_seq_add_if #(.DW(128)) if128 ();

  cla_seq_add #(.DW(64), .SW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (if64)
  );

  cla_seq_add #(.DW(128), .SW(32)) dut128 (
    .clk   (clk),
    .rst_n (rst128_n),
    .io    (if128)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Reference: full-width integer add; returns {ovf, cout, sum}.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic c);
    logic [64:0] t;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + {64'd0, c};
    o = (a[63] == b[63]) && (t[63] != a[63]);
    return {o, t[64], t[63:0]};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      4:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Per-cycle scoreboard for the 64-bit instance.
  bit          mon_pend = 1'b0;
  int          mon_e    = 0;
  logic [65:0] mon_exp  = '0;
  bit          mon_ir;
  bit          mon_ov;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_pend = 1'b0;
      mon_e    = 0;
    end else begin
      if (mon_pend) mon_e++;
      mon_ir = !mon_pend;
      mon_ov = mon_pend && (mon_e >= NS + 1);
      chk("mon_in_ready", 128'(if64.in_ready), 128'(mon_ir));
      chk("mon_out_valid", 128'(if64.out_valid), 128'(mon_ov));
      if (mon_ov) begin
        chk("mon_result", 128'({if64.ovf, if64.cout, if64.sum}), 128'(mon_exp));
      end
      if (mon_ov && if64.out_ready) begin
        mon_pend = 1'b0;
      end else if (mon_ir && if64.in_valid) begin
        mon_pend = 1'b1;
        mon_e    = 0;
        mon_exp  = model(if64.a, if64.b, if64.cin);
      end
    end
  end

  // Wait for a result; mode 0 randomises out_ready and junk in_valid, mode 1 holds out_ready high.
  task automatic wait_result(input int mode, output logic [65:0] got);
    got = '0;
    for (int n = 0; n < 60; n++) begin
      if64.out_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      if (mode == 0) begin
        if64.in_valid = 1'($urandom_range(0, 1));
        if64.a        = {$urandom, $urandom};
        if64.b        = {$urandom, $urandom};
        if64.cin      = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (if64.out_valid && if64.out_ready) begin
        got = {if64.ovf, if64.cout, if64.sum};
        @(posedge clk);
        #1;
        if64.out_ready = 1'b0;
        if64.in_valid  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    timeout("result_wait");
    if64.out_ready = 1'b0;
    if64.in_valid  = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic c,
                        input int mode, output logic [65:0] got);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    if64.a        = a;
    if64.b        = b;
    if64.cin      = c;
    if64.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if64.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("accept_wait");
    @(posedge clk);
    #1;
    if64.in_valid = 1'b0;
    if64.a        = {$urandom, $urandom};
    if64.b        = {$urandom, $urandom};
    if64.cin      = 1'($urandom_range(0, 1));
    wait_result(mode, got);
  endtask

  logic [65:0]  got;
  logic [63:0]  ra, rb, a2, b2;
  logic         rc, c2;
  int           n128;

  initial begin
    if64.in_valid  = 1'b0;
    if64.a         = '0;
    if64.b         = '0;
    if64.cin       = 1'b0;
    if64.out_ready = 1'b0;
    if128.in_valid  = 1'b0;
    if128.a         = '0;
    if128.b         = '0;
    if128.cin       = 1'b0;
    if128.out_ready = 1'b0;

    // Pin the model with hand-computed values.
    chk("model_carry", 128'(model(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0)), 128'({2'b00, 64'h0000_0001_0000_0000}));
    chk("model_ovf", 128'(model(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0)), 128'({2'b10, 64'h8000_0000_0000_0000}));
    chk("model_negovf", 128'(model(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0)), 128'({2'b11, 64'h0}));

    // Reset state.
    #22;
    chk("rst_in_ready", 128'(if64.in_ready), 128'(1'b1));
    chk("rst_out_valid", 128'(if64.out_valid), 128'(1'b0));
    chk("rst_sum", 128'(if64.sum), 128'(64'h0));
    chk("rst_cout_ovf", 128'({if64.cout, if64.ovf}), 128'(2'b00));
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rst128_n = 1'b1;

    // Directed cases with literal expectations {ovf, cout, sum}.
    run_op(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1, got);
    chk("basic_chain", 128'(got), 128'({2'b00, 64'h0000_0001_0000_0000}));
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1, got);
    chk("full_wrap", 128'(got), 128'({2'b01, 64'h0}));
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1, got);
    chk("signed_ovf", 128'(got), 128'({2'b10, 64'h8000_0000_0000_0000}));
    run_op(64'h0, 64'h0, 1'b1, 1, got);
    chk("cin_path", 128'(got), 128'({2'b00, 64'h1}));
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, got);
    chk("neg_ovf", 128'(got), 128'({2'b11, 64'h0}));

    // Backpressure with a new operand pair presented the whole time.
    ra = pick(); rb = pick(); rc = 1'($urandom_range(0, 1));
    a2 = pick(); b2 = pick(); c2 = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    if64.a = ra; if64.b = rb; if64.cin = rc; if64.in_valid = 1'b1; if64.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_accept_ready", 128'(if64.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    if64.a = a2; if64.b = b2; if64.cin = c2;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if64.out_valid) break;
    end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 128'(if64.out_valid), 128'(1'b1));
      chk("bp_in_ready", 128'(if64.in_ready), 128'(1'b0));
      chk("bp_hold", 128'({if64.ovf, if64.cout, if64.sum}), 128'(model(ra, rb, rc)));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if64.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if64.out_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", 128'(if64.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    if64.in_valid = 1'b0;
    wait_result(1, got);
    chk("bp_second", 128'(got), 128'(model(a2, b2, c2)));

    // Randomised operations with random backpressure.
    for (int i = 0; i < 40; i++) begin
      ra = pick(); rb = pick(); rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rc, 0, got);
      chk("rand_op", 128'(got), 128'(model(ra, rb, rc)));
    end

    // 128-bit instance: reset while the slice counter is 1.
    @(posedge clk);
    #1;
    if128.a = 128'h5; if128.b = 128'h3; if128.cin = 1'b0; if128.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if128.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst128_n = 1'b0;
    #1;
    chk("r128_valid_in_rst", 128'(if128.out_valid), 128'(1'b0));
    chk("r128_sum_in_rst", if128.sum, 128'h0);
    chk("r128_ready_in_rst", 128'(if128.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    rst128_n = 1'b1;
    @(negedge clk);
    chk("r128_ready_after", 128'(if128.in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    if128.a = 128'h1; if128.b = 128'h2; if128.cin = 1'b0; if128.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if128.in_valid = 1'b0;
    n128 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      n128 = n;
      if (if128.out_valid) break;
    end
    chk("r128_latency", 128'(n128), 128'(4));
    chk("r128_sum", if128.sum, 128'h3);
    chk("r128_cout_ovf", 128'({if128.cout, if128.ovf}), 128'(2'b00));
    if128.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if128.out_ready = 1'b0;
    chk("r128_drained", 128'({if128.out_valid, if128.in_ready}), 128'(2'b01));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
